// File: rtl/des_key_schedule_if.sv
// rtl/des_key_schedule_if.sv - control and subkey handshake bundle between the key schedule and its round engine
interface des_key_schedule_if;
    logic        start;
    logic [63:0] key;
    logic        decrypt;
    logic        abort;
    logic        busy;
    logic        k_valid;
    logic        k_ready;
    logic [47:0] subkey;
    logic [3:0]  k_round;
    logic        k_last;
    logic        done;

    modport master (
        output start, key, decrypt, abort, k_ready,
        input  busy, k_valid, subkey, k_round, k_last, done
    );

    modport slave (
        input  start, key, decrypt, abort, k_ready,
        output busy, k_valid, subkey, k_round, k_last, done
    );
endinterface

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - sequential DES subkey generator, K1..K16 (encrypt) or K16..K1 (decrypt)
module des_key_schedule (
    input  logic                 clk,
    input  logic                 rst_n,
    des_key_schedule_if.slave    bus
);
    typedef enum logic {ST_IDLE, ST_GEN} state_t;

    // Tables hold FIPS 1-based bit numbers; bit 1 is the MSB of the source word.
    localparam logic [7:0] PC1_TAB [56] = '{
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
        8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
        8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
        8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
    };
    localparam logic [7:0] PC2_TAB [48] = '{
        8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
        8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
        8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
        8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
    };
    // Bit i set when round i+1 shifts by two.
    localparam logic [15:0] ROT2 = 16'h7EFC;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        logic [5:0]  src;
        logic [5:0]  dst;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            src    = 6'(64 - int'(PC1_TAB[i]));
            dst    = 6'(55 - i);
            r[dst] = k[src];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        logic [5:0]  src;
        logic [5:0]  dst;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            src    = 6'(56 - int'(PC2_TAB[i]));
            dst    = 6'(47 - i);
            r[dst] = cd[src];
        end
        return r;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      r_state;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [3:0]  r_cnt;
    logic        r_dir;
    logic        r_done;

    logic [55:0] w_pc1;
    logic        w_gen;
    logic        w_rot2;

    assign w_pc1  = pc1(bus.key);
    assign w_gen  = (r_state == ST_GEN);
    // Encrypt steps to the next round's shift; decrypt undoes the current round's shift.
    assign w_rot2 = r_dir ? ROT2[~r_cnt] : ROT2[r_cnt + 4'd1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_c     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.abort) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            // Decrypt starts unrotated: the full schedule rotates by 28, so C0D0 == C16D16.
                            r_c     <= bus.decrypt ? w_pc1[55:28] : rotl(w_pc1[55:28], 1'b0);
                            r_d     <= bus.decrypt ? w_pc1[27:0]  : rotl(w_pc1[27:0], 1'b0);
                            r_dir   <= bus.decrypt;
                            r_cnt   <= '0;
                            r_state <= ST_GEN;
                        end
                    end
                    ST_GEN: begin
                        if (bus.k_ready) begin
                            if (r_cnt == 4'd15) begin
                                r_state <= ST_IDLE;
                                r_cnt   <= '0;
                                r_done  <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 4'd1;
                                r_c   <= r_dir ? rotr(r_c, w_rot2) : rotl(r_c, w_rot2);
                                r_d   <= r_dir ? rotr(r_d, w_rot2) : rotl(r_d, w_rot2);
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.busy    = w_gen;
    assign bus.k_valid = w_gen;
    assign bus.k_last  = w_gen && (r_cnt == 4'd15);
    assign bus.k_round = !w_gen ? 4'd0 : (r_dir ? ~r_cnt : r_cnt);
    assign bus.subkey  = pc2({r_c, r_d});
    assign bus.done    = r_done;
endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Sequential DES subkey generator that supplies the per-round 48-bit subkeys to the S-box round datapath. It supports both directions: K1..K16 for encryption (left rotations) and K16..K1 for decryption (right rotations), produced one per round. Subkeys are handed over through a valid/ready handshake so the round engine can stall. It sits between the key register and the round function's key-XOR stage.

## Interface
Parameters: none. All widths are fixed by FIPS 46-3.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a schedule; accepted only in IDLE.
- key  in  64  DES key; FIPS bit 1 = key[63]. Parity bits 8,16,…,64 are ignored.
- decrypt  in  1  sampled with start; 0 = K1→K16, 1 = K16→K1.
- abort  in  1  synchronous return to IDLE; no done pulse.
- busy  out  1  high while not in IDLE.
- k_valid  out  1  subkey/k_round are valid.
- k_ready  in  1  consumer accepts the subkey.
- subkey  out  48  PC-2(C,D); FIPS bit 1 = subkey[47].
- k_round  out  4  FIPS round index minus 1 of the presented subkey (K1 = 0, K16 = 15).
- k_last  out  1  high with the 16th subkey of the sequence.
- done  out  1  one-cycle pulse after the 16th handshake.

## Operation
- State: registers C[27:0], D[27:0], cnt[3:0], dir, and state in {IDLE, GEN}.
- subkey is combinational PC-2 of the registered C,D.
- Rotation table s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- IDLE with start=1:
  - Load {C,D} = PC-1(key).
  - If decrypt=0, rotate C and D left by 1 in the same load.
  - dir <= decrypt, cnt <= 0, go to GEN.
- GEN:
  - k_valid = 1.
  - Encrypt: k_round = cnt. Decrypt: k_round = 15 − cnt.
  - k_last = (cnt == 15).
- Handshake (k_valid & k_ready) with cnt < 15:
  - cnt++.
  - Encrypt: rotate left by s[cnt+2] (indexed by the new cnt+1).
  - Decrypt: rotate right by s[16−cnt] (the old cnt).
- Handshake with cnt == 15: go to IDLE and pulse done.
- k_valid=1 and k_ready=0: C, D, cnt and all outputs hold unchanged.
- start while busy: ignored.
- abort: return to IDLE next cycle and clear cnt. abort wins over a simultaneous handshake and over start.
- Decrypt first subkey equals PC-2(PC-1(key)), because the total rotation is 28.
- key and decrypt are don't-care after the start cycle.

## Timing
- Reset values: busy=0, k_valid=0, k_last=0, done=0, k_round=0, cnt=0, C=D=0, subkey=PC-2(0)=0.
- Asserting rst_n mid-schedule returns to IDLE immediately (asynchronous). No done pulse.
- Latency from start to first k_valid: 1 cycle. The start edge loads C,D, and k_valid is high in the next cycle.
- Throughput with k_ready held high: one subkey per cycle. 16 cycles from first k_valid to the done pulse.
- done is high in the cycle after the final handshake, coincident with busy=0 and k_valid=0.
- Back-to-back: start may be accepted in the same cycle done is high, since state is IDLE.

## Test plan
- Encrypt, key=0x133457799BBCDFF1, k_ready=1:
  - Subkeys in order: 0x1B02EFFC7072, 0x79AED9DBC9E5, …, last 0xCB3D8B0E17F5.
  - k_round 0..15; k_last only on the 16th; done one cycle later.
- Decrypt, same key:
  - First subkey 0xCB3D8B0E17F5 with k_round=15.
  - Second subkey equals encrypt K15, with k_round=14.
  - Last subkey 0x1B02EFFC7072 with k_round=0.
  - The full sequence is the exact reverse of the encrypt sequence.
- Random k_ready stalls (~50%) on an encrypt schedule:
  - subkey, k_round and k_last stay stable while stalled.
  - Exactly 16 handshakes occur.
  - Sequence matches the unstalled run.
- start pulsed again during GEN with a different key: ignored. Output sequence is unchanged.
- abort asserted after the 5th handshake:
  - Next cycle busy=0, k_valid=0; done never pulses.
  - A new start then yields a correct K1.
- rst_n low at the 8th subkey:
  - All outputs go to reset values asynchronously.
  - After release, busy stays 0 until start.
